hazard_stall_unit: RTL and testbench

- Pipeline interlock controller for the 5-stage CPU (IF, ID, EX, MEM, WB), which has no forwarding paths.
- Tracks in-flight register writes in a scoreboard and stalls instructions in ID that read a pending destination; a NOP bubble is injected into EX on each stall.
- Freezes the whole pipeline while the external data bus inserts wait states, with a watchdog on the wait.
- Keeps a saturating stall counter for performance measurement.

---
 rtl/hazard_stall_unit_pkg.sv | 21 ++
 rtl/hazard_stall_unit_scoreboard.sv | 67 ++++++
 rtl/hazard_stall_unit.sv | 111 +++++++++++
 tb/tb_hazard_stall_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline interlock controller.
// Scoreboard slots pair a valid bit with the destination register index.
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_slot_t;

  // All-zero control word, i.e. the NOP bubble as seen by the scoreboard
  localparam sb_slot_t NOP_SLOT = '{valid: 1'b0, rd: {REG_W{1'b0}}};

  // r0 is hard-wired zero, so it never creates a dependence
  function automatic logic reg_hit(input logic used, input logic [REG_W-1:0] src,
                                   input sb_slot_t slot);
    return used && slot.valid && (src == slot.rd) && (src != {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/hazard_stall_unit_scoreboard.sv
// Shift register of in-flight destination registers (slot 1 = EX .. DEPTH = WB)
// plus the source-operand compare that flags a read-after-write hazard.
module hazard_stall_unit_scoreboard
  import hazard_stall_unit_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter bit RF_BYPASS = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_en_i,
  input  logic             issue_valid_i,
  input  logic [REG_W-1:0] a_reg_i,
  input  logic [REG_W-1:0] b_reg_i,
  input  logic             a_used_i,
  input  logic             b_used_i,
  input  logic             ins_valid_i,
  input  logic [REG_W-1:0] ins_reg_i,
  output logic             hazard_o
);

  // With a bypassing register file the WB slot is already visible on read
  localparam int WINDOW = RF_BYPASS ? DEPTH - 1 : DEPTH;

  sb_slot_t slot_q [DEPTH];
  sb_slot_t slot_d [DEPTH];
  logic     hit_s;

  // Next slot contents: shift one stage towards WB unless the pipe is frozen
  always_comb begin
    slot_d = slot_q;
    if (shift_en_i) begin
      if (ins_valid_i && (ins_reg_i != {REG_W{1'b0}})) begin
        slot_d[0] = '{valid: 1'b1, rd: ins_reg_i};
      end else begin
        slot_d[0] = NOP_SLOT;
      end
      for (int k = 1; k < DEPTH; k++) begin
        slot_d[k] = slot_q[k-1];
      end
    end else begin
      slot_d = slot_q;
    end
  end

  // Hazard compare across the slots that the register file cannot cover
  always_comb begin
    hit_s = 1'b0;
    for (int k = 0; k < WINDOW; k++) begin
      hit_s = hit_s | reg_hit(a_used_i, a_reg_i, slot_q[k])
                    | reg_hit(b_used_i, b_reg_i, slot_q[k]);
    end
    hazard_o = issue_valid_i && hit_s;
  end

  // Slot storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= NOP_SLOT;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Interlock controller for a forwarding-less 5-stage pipeline: RAW stalls with
// bubble injection, bus wait-state freeze with watchdog, and a stall counter.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter bit RF_BYPASS = 1'b0,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] a_reg,
  input  logic [REG_W-1:0] b_reg,
  input  logic             a_used,
  input  logic             b_used,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_reg,
  input  logic             mem_wait,
  input  logic             count_clr,
  output logic             stall,
  output logic             bubble,
  output logic             freeze,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic             hazard_s;
  logic             freeze_s;
  logic             stall_s;
  logic             ins_valid_s;
  logic [WD_W-1:0]  wait_q, wait_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_stall_unit_scoreboard #(
    .DEPTH     (DEPTH),
    .RF_BYPASS (RF_BYPASS)
  ) u_scoreboard (
    .clk_i         (clk),
    .rst_ni        (rst),
    .shift_en_i    (!freeze_s),
    .issue_valid_i (issue_valid),
    .a_reg_i       (a_reg),
    .b_reg_i       (b_reg),
    .a_used_i      (a_used),
    .b_used_i      (b_used),
    .ins_valid_i   (ins_valid_s),
    .ins_reg_i     (wb_reg),
    .hazard_o      (hazard_s)
  );

  // Freeze dominates a stall: while frozen nothing advances, so no bubble
  always_comb begin
    freeze_s    = mem_wait && !bus_err_q;
    stall_s     = hazard_s && !freeze_s;
    ins_valid_s = issue_valid && !stall_s && wb_en;
  end

  // Watchdog on consecutive wait states; the error releases the freeze
  always_comb begin
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    if (!mem_wait) begin
      wait_d = {WD_W{1'b0}};
    end else if (!bus_err_q) begin
      if (wait_q == WD_W'(TIMEOUT)) begin
        bus_err_d = 1'b1;
      end else begin
        wait_d = wait_q + WD_W'(1);
      end
    end else begin
      wait_d = wait_q;
    end
  end

  // Saturating stall counter, clear has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q    <= {WD_W{1'b0}};
      bus_err_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign stall       = stall_s;
  assign bubble      = stall_s;
  assign freeze      = freeze_s;
  assign bus_err     = bus_err_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: default, RF_BYPASS=1 and CNT_W=4 instances,
// table-driven vectors plus hand-built sequences for stall chains and watchdog.
module tb_hazard_stall_unit;

  typedef struct {
    logic        tgt;     // 0: default + CNT_W=4 instances, 1: bypass instance
    logic        iv;
    logic [4:0]  a;
    logic        au;
    logic [4:0]  b;
    logic        bu;
    logic        we;
    logic [4:0]  wr;
    logic        mw;
    logic        clr;
    logic        e_stall;
    logic        e_freeze;
    logic        e_berr;
    logic [15:0] e_cnt;
    logic [3:0]  e_cnt4;
  } vec_t;

  logic clk;
  logic rst;

  logic       m_iv, m_au, m_bu, m_we, m_mw, m_clr;
  logic [4:0] m_a, m_b, m_wr;
  logic       p_iv, p_au, p_bu, p_we, p_mw, p_clr;
  logic [4:0] p_a, p_b, p_wr;

  logic        stall_m, bubble_m, freeze_m, berr_m;
  logic [15:0] cnt_m;
  logic        stall_c, bubble_c, freeze_c, berr_c;
  logic [3:0]  cnt_c;
  logic        stall_p, bubble_p, freeze_p, berr_p;
  logic [15:0] cnt_p;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .issue_valid(m_iv), .a_reg(m_a), .b_reg(m_b),
    .a_used(m_au), .b_used(m_bu), .wb_en(m_we), .wb_reg(m_wr),
    .mem_wait(m_mw), .count_clr(m_clr), .stall(stall_m), .bubble(bubble_m),
    .freeze(freeze_m), .bus_err(berr_m), .stall_count(cnt_m)
  );

  hazard_stall_unit #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .issue_valid(m_iv), .a_reg(m_a), .b_reg(m_b),
    .a_used(m_au), .b_used(m_bu), .wb_en(m_we), .wb_reg(m_wr),
    .mem_wait(m_mw), .count_clr(m_clr), .stall(stall_c), .bubble(bubble_c),
    .freeze(freeze_c), .bus_err(berr_c), .stall_count(cnt_c)
  );

  hazard_stall_unit #(.RF_BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .issue_valid(p_iv), .a_reg(p_a), .b_reg(p_b),
    .a_used(p_au), .b_used(p_bu), .wb_en(p_we), .wb_reg(p_wr),
    .mem_wait(p_mw), .count_clr(p_clr), .stall(stall_p), .bubble(bubble_p),
    .freeze(freeze_p), .bus_err(berr_p), .stall_count(cnt_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int tgt, input int iv, input int a, input int au,
                              input int b, input int bu, input int we, input int wr,
                              input int mw, input int clr, input int es, input int ef,
                              input int eb, input int ec);
    vec_t v;
    v.tgt = (tgt != 0);  v.iv = (iv != 0);  v.a = 5'(a);   v.au = (au != 0);
    v.b = 5'(b);         v.bu = (bu != 0);  v.we = (we != 0); v.wr = 5'(wr);
    v.mw = (mw != 0);    v.clr = (clr != 0);
    v.e_stall = (es != 0); v.e_freeze = (ef != 0); v.e_berr = (eb != 0);
    v.e_cnt = 16'(ec);   v.e_cnt4 = (ec > 15) ? 4'd15 : 4'(ec);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_all();
    m_iv = 1'b0; m_a = 5'd0; m_au = 1'b0; m_b = 5'd0; m_bu = 1'b0;
    m_we = 1'b0; m_wr = 5'd0; m_mw = 1'b0; m_clr = 1'b0;
    p_iv = 1'b0; p_a = 5'd0; p_au = 1'b0; p_b = 5'd0; p_bu = 1'b0;
    p_we = 1'b0; p_wr = 5'd0; p_mw = 1'b0; p_clr = 1'b0;
  endtask

  // One clock cycle: drive after the rising edge, compare on the falling edge
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    idle_all();
    if (v.tgt) begin
      p_iv = v.iv; p_a = v.a; p_au = v.au; p_b = v.b; p_bu = v.bu;
      p_we = v.we; p_wr = v.wr; p_mw = v.mw; p_clr = v.clr;
    end else begin
      m_iv = v.iv; m_a = v.a; m_au = v.au; m_b = v.b; m_bu = v.bu;
      m_we = v.we; m_wr = v.wr; m_mw = v.mw; m_clr = v.clr;
    end
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.tgt) begin
      chk({tag, ".byp_stall"},  32'(stall_p),  32'(e.e_stall));
      chk({tag, ".byp_bubble"}, 32'(bubble_p), 32'(e.e_stall));
      chk({tag, ".byp_freeze"}, 32'(freeze_p), 32'(e.e_freeze));
      chk({tag, ".byp_buserr"}, 32'(berr_p),   32'(e.e_berr));
      chk({tag, ".byp_count"},  32'(cnt_p),    32'(e.e_cnt));
    end else begin
      chk({tag, ".stall"},     32'(stall_m),  32'(e.e_stall));
      chk({tag, ".bubble"},    32'(bubble_m), 32'(e.e_stall));
      chk({tag, ".freeze"},    32'(freeze_m), 32'(e.e_freeze));
      chk({tag, ".bus_err"},   32'(berr_m),   32'(e.e_berr));
      chk({tag, ".count"},     32'(cnt_m),    32'(e.e_cnt));
      chk({tag, ".c4_stall"},  32'(stall_c),  32'(e.e_stall));
      chk({tag, ".c4_bubble"}, 32'(bubble_c), 32'(e.e_stall));
      chk({tag, ".c4_freeze"}, 32'(freeze_c), 32'(e.e_freeze));
      chk({tag, ".c4_buserr"}, 32'(berr_c),   32'(e.e_berr));
      chk({tag, ".c4_count"},  32'(cnt_c),    32'(e.e_cnt4));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ec;
    vec_t v;
    //             tgt iv  a au  b bu we wr mw clr st fr be cnt
    // back-to-back dependence on r5: three stall cycles
    tbl.push_back(mk(0, 1, 1, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 1, 6, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 1, 6, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 1, 6, 0, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    // r0 never tracked; matching B ignored when b_used=0
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 7, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    // A and B both hit r9, frozen for 4 cycles mid-stall
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 9, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 3));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 9, 1, 9, 1, 0, 0, 1, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 1, 9, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 1, 9, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(0, 1, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 6));
    // consumer one behind; producer in last slot still stalls; clear wins
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // RF_BYPASS=1: back-to-back 2 cycles, one behind 1 cycle, two behind 0
    tbl.push_back(mk(1, 1, 1, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));

    idle_all();
    rst = 1'b0;
    #2;
    chk("rst.stall",   32'(stall_m),  32'd0);
    chk("rst.bubble",  32'(bubble_m), 32'd0);
    chk("rst.freeze",  32'(freeze_m), 32'd0);
    chk("rst.bus_err", 32'(berr_m),   32'd0);
    chk("rst.count",   32'(cnt_m),    32'd0);
    chk("rst.byp_cnt", 32'(cnt_p),    32'd0);
    chk("rst.byp_err", 32'(berr_p),   32'd0);
    m_mw = 1'b1;
    #1;
    chk("rst.freeze_follows_wait", 32'(freeze_m), 32'd1);
    m_mw = 1'b0;
    #9;
    rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Self-dependent chain on r5: pattern issue,S,S,S; counter saturation on CNT_W=4
    ec = 0;
    for (int i = 0; i < 32; i++) begin
      v = mk(0, 1, 5, 1, 0, 0, 1, 5, 0, (i == 29) ? 1 : 0,
             (i % 4 != 0) ? 1 : 0, 0, 0, ec);
      apply(v, $sformatf("chain%0d", i));
      if (i == 29) ec = 0;
      else if (i % 4 != 0) ec++;
    end

    // Reset mid-stall releases the stall and clears the counters at once
    rst = 1'b0;
    #1;
    chk("rst_mid.stall",    32'(stall_m),  32'd0);
    chk("rst_mid.bubble",   32'(bubble_m), 32'd0);
    chk("rst_mid.count",    32'(cnt_m),    32'd0);
    chk("rst_mid.c4_count", 32'(cnt_c),    32'd0);
    rst = 1'b1;

    // Watchdog: 256 frozen cycles, then bus_err and freeze drops
    for (int i = 0; i < 262; i++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, (i < 256) ? 1 : 0, (i >= 256) ? 1 : 0, 0);
      apply(v, $sformatf("wd%0d", i));
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "wd_sticky");
    rst = 1'b0;
    #1;
    chk("wd_rst.bus_err", 32'(berr_m), 32'd0);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
